icache_data_array: RTL and testbench

- Parametrised N-way set-associative instruction-cache data array. Generalises the fixed 2-way, 64-set, 8-byte-line icache data store.
- Adds configurable ways, sets and line size, plus a multi-beat refill engine that accepts AXI-style read bursts one beat per cycle.
- Read port has registered, stall-holding output.
- Sits between the tag/LRU compare logic (which supplies hit and victim way) and the fetch stage / AXI refill path.

---
 rtl/icache_data_array.sv | 115 +++++++++++
 tb/tb_icache_data_array.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/icache_data_array.sv
// icache_data_array: N-way set-associative icache data store with 1-cycle read and beat-wise refill engine
module icache_data_array #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic [WAYS-1:0]         rd_hit_way,
  output logic                    rd_ready,
  output logic                    rd_valid,
  output logic                    rd_hit,
  output logic [63:0]             rd_data,
  input  logic                    refill_start,
  input  logic [$clog2(SETS)-1:0] refill_index,
  input  logic [WAYS-1:0]         refill_way,
  input  logic                    refill_valid,
  input  logic [63:0]             refill_data,
  input  logic                    refill_last,
  output logic                    refill_ready,
  output logic                    refill_busy,
  output logic                    refill_done,
  output logic                    refill_err
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int BEATS  = LINE_BYTES / 8;
  localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int WAY_W  = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int WHI    = OFF_W > 3 ? OFF_W - 1 : 3;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WAYS-1:0] way_q, way_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic rd_valid_q, rd_valid_d, rd_hit_q, rd_hit_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic [63:0] mem [WAYS][SETS][BEATS];
  logic [WAY_W-1:0] hit_way;
  logic [IDX_W-1:0] rd_idx;
  logic [BEAT_W-1:0] rd_word;
  logic rd_accept, last_beat, wr_en;
  logic unused_addr;
  assign unused_addr = ^{rd_addr[ADDR_W-1:OFF_W+IDX_W], rd_addr[2:0]};
  assign rd_idx    = rd_addr[OFF_W+IDX_W-1:OFF_W];
  assign rd_word   = BEATS > 1 ? rd_addr[WHI:3] : '0;
  assign rd_ready  = (state_q == IDLE) & ~refill_start & ~rst;
  assign rd_accept = rd_en & rd_ready & ~stall;
  assign last_beat = cnt_q == BEAT_W'(BEATS - 1);
  assign wr_en     = (state_q == FILL) & refill_valid & ~rst;
  // lowest-numbered hit wins so a multi-hit upstream bug stays deterministic
  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) if (rd_hit_way[i]) hit_way = WAY_W'(i);
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (state_q == IDLE && refill_start) begin
      state_d = FILL;
      idx_d   = refill_index;
      way_d   = refill_way;
      cnt_d   = '0;
    end
    if (state_q == FILL && refill_valid) begin
      cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      state_d = last_beat ? DONE : FILL;
      err_d = err_q | (refill_last != last_beat);
    end
    if (state_q == DONE) state_d = IDLE;
    rd_valid_d = stall ? rd_valid_q : rd_accept;
    rd_hit_d   = rd_accept ? |rd_hit_way : rd_hit_q;
    rd_data_d  = rd_accept ? (|rd_hit_way ? mem[hit_way][rd_idx][rd_word] : '0) : rd_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      way_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      way_q      <= way_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_hit_q   <= rd_hit_d;
      rd_data_q  <= rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int w = 0; w < WAYS; w++) if (way_q[w]) mem[w][idx_q][cnt_q] <= refill_data;
  end
  assign rd_valid     = rd_valid_q;
  assign rd_hit       = rd_hit_q;
  assign rd_data      = rd_data_q;
  assign refill_ready = state_q == FILL;
  assign refill_busy  = state_q != IDLE;
  assign refill_done  = state_q == DONE;
  assign refill_err   = err_q;
endmodule

// File: tb/tb_icache_data_array.sv
// tb_icache_data_array: directed checks of a default (2-way) and a 4-way/32-byte-line instance
module tb_icache_data_array;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic a_stall = 0, a_rd_en = 0, a_rs = 0, a_rv = 0, a_rl = 0;
  logic [63:0] a_addr = 0, a_rdat = 0, a_data;
  logic [1:0] a_hit = 0, a_rw = 0;
  logic [5:0] a_ri = 0;
  logic a_ready, a_valid, a_rhit, a_rr, a_rb, a_dn, a_re;
  logic b_stall = 0, b_rd_en = 0, b_rs = 0, b_rv = 0, b_rl = 0;
  logic [63:0] b_addr = 0, b_rdat = 0, b_data;
  logic [3:0] b_hit = 0, b_rw = 0, b_ri = 0;
  logic b_ready, b_valid, b_rhit, b_rr, b_rb, b_dn, b_re;
  icache_data_array u_a (
    .clk(clk), .rst(rst), .stall(a_stall), .rd_en(a_rd_en), .rd_addr(a_addr), .rd_hit_way(a_hit),
    .rd_ready(a_ready), .rd_valid(a_valid), .rd_hit(a_rhit), .rd_data(a_data),
    .refill_start(a_rs), .refill_index(a_ri), .refill_way(a_rw), .refill_valid(a_rv),
    .refill_data(a_rdat), .refill_last(a_rl), .refill_ready(a_rr), .refill_busy(a_rb),
    .refill_done(a_dn), .refill_err(a_re));
  icache_data_array #(.WAYS(4), .SETS(16), .LINE_BYTES(32)) u_b (
    .clk(clk), .rst(rst), .stall(b_stall), .rd_en(b_rd_en), .rd_addr(b_addr), .rd_hit_way(b_hit),
    .rd_ready(b_ready), .rd_valid(b_valid), .rd_hit(b_rhit), .rd_data(b_data),
    .refill_start(b_rs), .refill_index(b_ri), .refill_way(b_rw), .refill_valid(b_rv),
    .refill_data(b_rdat), .refill_last(b_rl), .refill_ready(b_rr), .refill_busy(b_rb),
    .refill_done(b_dn), .refill_err(b_re));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic a_beat(input logic [63:0] d, input logic l);
    a_rv = 1; a_rdat = d; a_rl = l;
    tick();
    a_rv = 0; a_rl = 0;
  endtask
  task automatic b_beat(input logic v, input logic [63:0] d, input logic l);
    b_rv = v; b_rdat = d; b_rl = l;
    tick();
    b_rv = 0; b_rl = 0;
  endtask
  task automatic a_read(input logic [63:0] addr, input logic [1:0] hit);
    a_rd_en = 1; a_addr = addr; a_hit = hit;
    tick();
    a_rd_en = 0;
  endtask
  task automatic b_read(input logic [63:0] addr, input logic [3:0] hit);
    b_rd_en = 1; b_addr = addr; b_hit = hit;
    tick();
    b_rd_en = 0;
  endtask
  initial begin
    tick(); tick();
    chk("reset_flags", {a_valid, a_rhit, a_rr, a_rb, a_dn, a_re, a_ready}, 0);
    chk("reset_data", a_data, 0);
    chk("reset_flags_b", {b_valid, b_rhit, b_rr, b_rb, b_dn, b_re, b_ready}, 0);
    rst = 0; #1;
    chk("ready_after_rst", a_ready, 1);
    a_read(64'h0, 2'b00);
    chk("miss_valid_hit", {a_valid, a_rhit}, 2'b10);
    chk("miss_data", a_data, 0);
    a_rs = 1; a_ri = 5; a_rw = 2'b10;
    tick();
    a_rs = 0;
    chk("fill_ready_busy", {a_rr, a_rb, a_ready}, 3'b110);
    a_beat(64'hA0, 0);
    chk("fill_ready_beat1", a_rr, 1);
    a_beat(64'hA1, 1);
    chk("done_pulse", {a_dn, a_rb, a_rr}, 3'b110);
    tick();
    chk("idle_after_done", {a_dn, a_rb, a_re}, 0);
    a_read(64'h50, 2'b10);
    chk("rd_a0", a_data, 64'hA0);
    chk("rd_a0_flags", {a_valid, a_rhit}, 2'b11);
    a_read(64'h58, 2'b10);
    chk("rd_a1", a_data, 64'hA1);
    tick();
    chk("no_accept_valid", a_valid, 0);
    chk("no_accept_hold", a_data, 64'hA1);
    a_read(64'h50, 2'b10);
    a_stall = 1; a_rd_en = 1; a_addr = 64'h58;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {a_valid, a_rhit, a_data}, {2'b11, 64'hA0});
    end
    a_stall = 0; a_rd_en = 0;
    tick();
    chk("after_stall_valid", a_valid, 0);
    a_rs = 1; a_ri = 3; a_rw = 2'b01; a_rd_en = 1; a_addr = 64'h50; a_hit = 2'b10; #1;
    chk("start_blocks_ready", a_ready, 0);
    tick();
    a_rs = 0; a_rd_en = 0;
    chk("start_no_valid", a_valid, 0);
    chk("fill_busy", {a_rb, a_ready}, 2'b10);
    a_beat(64'hB0, 0);
    a_beat(64'hB1, 1);
    tick();
    a_read(64'h30, 2'b01);
    chk("rd_b0", a_data, 64'hB0);
    a_read(64'h38, 2'b11);
    chk("multihit_lowest", a_data, 64'hB1);
    a_rs = 1; a_ri = 5; a_rw = 2'b00;
    tick();
    a_rs = 0;
    a_beat(64'hDEAD, 0);
    a_beat(64'hBEEF, 1);
    chk("noway_done", a_dn, 1);
    tick();
    a_read(64'h50, 2'b10);
    chk("noway_nowrite", a_data, 64'hA0);
    b_rs = 1; b_ri = 7; b_rw = 4'b0100;
    tick();
    b_rs = 0;
    b_beat(1, 64'hC0, 0);
    b_beat(0, 64'h0, 0);
    b_beat(1, 64'hC1, 0);
    chk("b_err_before", b_re, 0);
    b_beat(1, 64'hC2, 1);
    chk("b_err_early_last", b_re, 1);
    b_beat(0, 64'h0, 0);
    chk("b_still_fill", b_rr, 1);
    b_beat(1, 64'hC3, 0);
    chk("b_done", {b_dn, b_rb}, 2'b11);
    tick();
    b_read(64'hE0, 4'b0100); chk("b_w0", b_data, 64'hC0);
    b_read(64'hE8, 4'b0100); chk("b_w1", b_data, 64'hC1);
    b_read(64'hF0, 4'b0100); chk("b_w2", b_data, 64'hC2);
    b_read(64'hF8, 4'b0100); chk("b_w3", b_data, 64'hC3);
    chk("b_err_sticky", b_re, 1);
    b_rs = 1; b_ri = 2; b_rw = 4'b0001;
    tick();
    b_rs = 0;
    b_beat(1, 64'hD0, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("b_rst_idle", {b_rb, b_rr, b_dn, b_re}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_no_done", b_dn, 0);
    end
    b_rs = 1; b_ri = 2; b_rw = 4'b0001;
    tick();
    b_rs = 0;
    chk("b_restart_fill", b_rr, 1);
    b_beat(1, 64'hE0, 0);
    b_beat(1, 64'hE1, 0);
    b_beat(1, 64'hE2, 0);
    b_beat(1, 64'hE3, 1);
    chk("b_restart_done", {b_dn, b_re}, 2'b10);
    tick();
    b_read(64'h40, 4'b0001); chk("b_e0", b_data, 64'hE0);
    b_read(64'h58, 4'b0001); chk("b_e3", b_data, 64'hE3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
